// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake. Single-cycle logic/arith/shift ops
// complete on the accepting edge; MUL/MULHU run an iterative shift-add over WORD_SIZE cycles.
module alu_seq #(
    parameter int unsigned WORD_SIZE = 18,
    parameter int unsigned CNT_W     = $clog2(WORD_SIZE + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WORD_SIZE-1:0] r0,
    input  logic [WORD_SIZE-1:0] r1,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] res,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_n
);

    localparam int unsigned W = WORD_SIZE;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    typedef enum logic [3:0] {
        OP_REG0  = 4'd0,
        OP_REG1  = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOT   = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_SAR   = 4'd10,
        OP_MUL   = 4'd11,
        OP_MULHU = 4'd12
    } op_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        mcand_q, mcand_d;
    logic [2*W-1:0]      acc_q, acc_d;
    logic                hi_sel_q, hi_sel_d;
    logic [W-1:0]        res_q, res_d;
    logic                z_q, z_d, c_q, c_d, n_q, n_d;
    logic                done_q, done_d;

    logic [W-1:0]        alu_res;
    logic                alu_c;
    logic [W:0]          sum_w, diff_w, shl_w, shr_w;
    logic signed [W:0]   sar_w;
    logic                amt_big;
    logic [W:0]          step;
    logic                wr;
    logic [W-1:0]        wr_res;
    logic                wr_c;

    always_comb begin
        sum_w   = {1'b0, r0} + {1'b0, r1};
        diff_w  = {1'b0, r0} - {1'b0, r1};
        // Extra bit beyond the word captures the last bit shifted out.
        shl_w   = {1'b0, r0} << r1;
        shr_w   = {r0, 1'b0} >> r1;
        sar_w   = $signed({r0, 1'b0}) >>> r1;
        amt_big = (r1 >= W'(WORD_SIZE));
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_t'(op))
            OP_REG0: alu_res = r0;
            OP_REG1: alu_res = r1;
            OP_ADD:  {alu_c, alu_res} = sum_w;
            OP_SUB:  {alu_c, alu_res} = diff_w;
            OP_AND:  alu_res = r0 & r1;
            OP_OR:   alu_res = r0 | r1;
            OP_XOR:  alu_res = r0 ^ r1;
            OP_NOT:  alu_res = ~r1;
            OP_SHL:  if (!amt_big) {alu_c, alu_res} = shl_w;
            OP_SHR:  if (!amt_big) {alu_res, alu_c} = shr_w;
            OP_SAR:  {alu_res, alu_c} = sar_w;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        hi_sel_d = hi_sel_q;
        res_d    = res_q;
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
        done_d   = 1'b0;
        wr       = 1'b0;
        wr_res   = '0;
        wr_c     = 1'b0;
        step     = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL || op == OP_MULHU) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        mcand_d  = r0;
                        acc_d    = {{W{1'b0}}, r1};
                        hi_sel_d = (op == OP_MULHU);
                    end else begin
                        wr     = 1'b1;
                        wr_res = alu_res;
                        wr_c   = alu_c;
                    end
                end
            end
            S_MUL: begin
                // Multiplier sits in the low half and is consumed one bit per step.
                acc_d = {step, acc_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = S_IDLE;
                    wr      = 1'b1;
                    wr_res  = hi_sel_q ? acc_d[2*W-1:W] : acc_d[W-1:0];
                    wr_c    = hi_sel_q ? |acc_d[W-1:0] : |acc_d[2*W-1:W];
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wr) begin
            res_d  = wr_res;
            z_d    = (wr_res == '0);
            c_d    = wr_c;
            n_d    = wr_res[W-1];
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            hi_sel_q <= 1'b0;
            res_q    <= '0;
            z_q      <= 1'b1;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            hi_sel_q <= hi_sel_d;
            res_q    <= res_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_MUL);
    assign done   = done_q;
    assign res    = res_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_n = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model plus directed literal cases.
module tb_alu_seq;

    localparam int W = 18;
    localparam longint unsigned M = (64'd1 << W) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  r0, r1;
    logic          busy, done, flag_z, flag_c, flag_n;
    logic [W-1:0]  res;

    int checks = 0;
    int errors = 0;

    int            m_left;
    logic [W-1:0]  m_pres;
    logic          m_pc;
    logic [W-1:0]  e_res;
    logic          e_z, e_c, e_n, e_done;

    alu_seq #(.WORD_SIZE(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op), .r0(r0), .r1(r1),
        .busy(busy), .done(done), .res(res), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
    );

    always #5 clock = ~clock;

    function automatic void model_op(input int o, input longint unsigned a, input longint unsigned b,
                                     output logic [W-1:0] r, output logic c);
        longint unsigned t;
        longint sa;
        longint unsigned sgn;
        t = 0;
        c = 1'b0;
        sgn = (a >> (W - 1)) & 1;
        case (o)
            0: t = a;
            1: t = b;
            2: begin t = a + b; c = ((t >> W) & 1) != 0; end
            3: begin t = a - b; c = (a < b); end
            4: t = a & b;
            5: t = a | b;
            6: t = a ^ b;
            7: t = ~b;
            8: if (b == 0) t = a;
               else if (b < W) begin t = a << b; c = ((a >> (W - b)) & 1) != 0; end
            9: if (b == 0) t = a;
               else if (b < W) begin t = a >> b; c = ((a >> (b - 1)) & 1) != 0; end
            10: if (b == 0) t = a;
                else if (b >= W) begin t = (sgn != 0) ? M : 0; c = (sgn != 0); end
                else begin
                    sa = (sgn != 0) ? longint'(a) - longint'(64'd1 << W) : longint'(a);
                    t = longint'(sa >>> b);
                    c = ((a >> (b - 1)) & 1) != 0;
                end
            11: begin t = a * b; c = (t >> W) != 0; end
            12: begin t = (a * b) >> W; c = ((a * b) & M) != 0; end
            default: t = 0;
        endcase
        r = W'(t & M);
    endfunction

    function automatic void model_write(input logic [W-1:0] r, input logic c);
        e_res  = r;
        e_c    = c;
        e_z    = (r == '0);
        e_n    = r[W-1];
        e_done = 1'b1;
    endfunction

    function automatic void model_reset();
        m_left = 0;
        e_res  = '0;
        e_z    = 1'b1;
        e_c    = 1'b0;
        e_n    = 1'b0;
        e_done = 1'b0;
    endfunction

    function automatic void model_step(input logic st, input int o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic c;
        e_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) model_write(m_pres, m_pc);
        end else if (st) begin
            model_op(o, longint'(a), longint'(b), r, c);
            if (o == 11 || o == 12) begin
                m_left = W;
                m_pres = r;
                m_pc   = c;
            end else begin
                model_write(r, c);
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        checks++;
        if (busy !== (m_left > 0) || done !== e_done || res !== e_res ||
            flag_z !== e_z || flag_c !== e_c || flag_n !== e_n) begin
            errors++;
            $display("FAIL %s @%0t: got busy=%b done=%b res=%h z=%b c=%b n=%b, want busy=%b done=%b res=%h z=%b c=%b n=%b",
                     tag, $time, busy, done, res, flag_z, flag_c, flag_n,
                     (m_left > 0), e_done, e_res, e_z, e_c, e_n);
        end
    endtask

    task automatic lit(input string tag, input longint unsigned got, input longint unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Called at a negedge: drives inputs, steps the model at the posedge, compares at the next negedge.
    task automatic tick(input logic st, input int o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = st;
        op    = 4'(o);
        r0    = a;
        r1    = b;
        @(posedge clock);
        model_step(st, o, a, b);
        @(negedge clock);
        compare_all("cycle");
    endtask

    task automatic issue_wait(input int o, input logic [W-1:0] a, input logic [W-1:0] b, output int edges);
        tick(1'b1, o, a, b);
        edges = 1;
        while (!done && edges < 40) begin
            tick(1'b0, 0, '0, '0);
            edges++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL timeout: got no done after %0d edges, want done", edges);
        end
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return W'(M);
            2: return W'(18'h20000);
            3: return W'($urandom_range(0, 24));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n, nbusy;
        logic [W-1:0] a, b;
        int o;

        reset_n = 1'b0;
        start = 1'b0; op = '0; r0 = '0; r1 = '0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all("reset");
        lit("reset_z", flag_z, 1);
        reset_n = 1'b1;

        // 1: ADD wraps to zero with carry
        issue_wait(2, W'(18'h3FFFF), W'(1), n);
        lit("add_edges", n, 1);
        lit("add_res", res, 0);
        lit("add_zcn", {flag_z, flag_c, flag_n}, 3'b110);

        // 2: SUB borrow and the legacy ops
        issue_wait(3, W'(5), W'(7), n);
        lit("sub_res", res, 18'h3FFFE);
        lit("sub_zcn", {flag_z, flag_c, flag_n}, 3'b011);
        issue_wait(7, W'(0), W'(18'h0F0F0), n);
        lit("not_res", res, 18'h30F0F);
        issue_wait(6, W'(18'h3C3C3), W'(18'h0FFFF), n);
        lit("xor_res", res, 18'h33C3C);

        // 3: shifts
        issue_wait(10, W'(18'h20000), W'(20), n);
        lit("sar_res", res, 18'h3FFFF);
        lit("sar_c", flag_c, 1);
        issue_wait(8, W'(18'h20001), W'(1), n);
        lit("shl_res", res, 18'h00002);
        lit("shl_c", flag_c, 1);
        issue_wait(9, W'(3), W'(0), n);
        lit("shr0_res", res, 3);
        lit("shr0_c", flag_c, 0);
        issue_wait(9, W'(18'h3FFFF), W'(18), n);
        lit("shr_big", {res, flag_c}, 0);

        // 4: multiply latency and words
        tick(1'b1, 11, W'(18'h3FFFF), W'(18'h3FFFF));
        n = 1; nbusy = (busy === 1'b1) ? 1 : 0;
        while (!done && n < 40) begin
            tick(1'b0, 0, '0, '0);
            n++;
            if (busy === 1'b1) nbusy++;
        end
        lit("mul_edges", n, W + 1);
        lit("mul_busy_cycles", nbusy, W);
        lit("mul_res", res, 1);
        lit("mul_c", flag_c, 1);
        issue_wait(12, W'(18'h3FFFF), W'(18'h3FFFF), n);
        lit("mulhu_res", res, 18'h3FFFE);
        lit("mulhu_c", flag_c, 1);

        // 5: start while busy is dropped; start in done cycle is accepted
        tick(1'b1, 11, W'(300), W'(7));
        n = 1;
        while (!done && n < 40) begin
            tick(1'b1, 2, W'(1), W'(1));
            n++;
        end
        lit("busy_ignore_edges", n, W + 1);
        lit("busy_ignore_res", res, 2100);
        tick(1'b1, 2, W'(40), W'(2));
        lit("b2b_done", done, 1);
        lit("b2b_res", res, 42);

        // 6: reset during a multiply
        tick(1'b1, 11, W'(18'h3FFFF), W'(18'h3FFFF));
        repeat (9) tick(1'b0, 0, '0, '0);
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all("mid_reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (W + 2) tick(1'b0, 0, '0, '0);
        issue_wait(14, W'(18'h12345), W'(18'h3FFFF), n);
        lit("illegal_res", res, 0);
        lit("illegal_zcn", {flag_z, flag_c, flag_n}, 3'b100);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            o = $urandom_range(0, 15);
            a = rnd_operand();
            b = rnd_operand();
            tick(($urandom_range(0, 2) != 0), o, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

endmodule
